// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared opcodes, FSM state encoding and default width for mul_div_unit
package mul_div_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/mul_div_datapath.sv
// rtl/mul_div_datapath.sv - unsigned shift-add multiplier / restoring divider, one bit per step
module mul_div_datapath
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   mag_a_i,
    input  logic [WIDTH-1:0]   mag_b_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quot_o,
    output logic [WIDTH-1:0]   rem_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // Multiply: low half holds the multiplier, consumed LSB first while the product grows in the high half.
    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: the trial subtraction is one bit wider so its borrow shows up in diff[WIDTH].
    assign shifted = {rem_q, acc_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd_q};

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        rem_d  = rem_q;
        if (load_i) begin
            acc_d  = {{WIDTH{1'b0}}, (is_div_i ? mag_a_i : mag_b_i)};
            opnd_d = is_div_i ? mag_b_i : mag_a_i;
            rem_d  = '0;
        end else if (step_i) begin
            if (is_div_i) begin
                rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            opnd_q <= '0;
            rem_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            rem_q  <= rem_d;
        end
    end

    assign prod_o = acc_q;
    assign quot_o = acc_q[WIDTH-1:0];
    assign rem_o  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle signed/unsigned multiply/divide unit with Start/Busy/Done handshake
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Zero,
    output logic             DivZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             res_neg_q, res_neg_d, dvd_neg_q, dvd_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             zero_q, zero_d, dz_q, dz_d;

    logic             is_signed, is_div, div_zero, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, quot, rem, quot_s, rem_s, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];
    assign div_zero  = is_div && (b_q == '0);
    assign a_neg     = is_signed & a_q[WIDTH-1];
    assign b_neg     = is_signed & b_q[WIDTH-1];
    assign mag_a     = a_neg ? -a_q : a_q;
    assign mag_b     = b_neg ? -b_q : b_q;

    mul_div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .load_i   (state_q == S_PREP),
        .step_i   (state_q == S_CALC),
        .is_div_i (is_div),
        .mag_a_i  (mag_a),
        .mag_b_i  (mag_b),
        .prod_o   (prod),
        .quot_o   (quot),
        .rem_o    (rem)
    );

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign prod_s = res_neg_q ? -prod : prod;
    assign quot_s = res_neg_q ? -quot : quot;
    assign rem_s  = dvd_neg_q ? -rem  : rem;

    always_comb begin
        fix_hi = prod_s[2*WIDTH-1:WIDTH];
        fix_lo = prod_s[WIDTH-1:0];
        if (div_zero) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = rem_s;
            fix_lo = quot_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        dvd_neg_d = dvd_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        zero_d    = zero_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start) begin
                    op_d    = Op;
                    a_d     = A;
                    b_d     = B;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d     = CW'(WIDTH - 1);
                res_neg_d = a_neg ^ b_neg;
                dvd_neg_d = a_neg;
                state_d   = div_zero ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                zero_d  = ({fix_hi, fix_lo} == '0);
                dz_d    = div_zero;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            dvd_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            zero_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            dvd_neg_q <= dvd_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            zero_q    <= zero_d;
            dz_q      <= dz_d;
        end
    end

    assign Busy    = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
    assign Done    = (state_q == S_DONE);
    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign Zero    = zero_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit against an arithmetic model
module tb_mul_div_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Done, Zero, DivZero;
    logic [31:0] Hi, Lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi, prev_lo;
    bit          prev_valid = 1'b0;

    mul_div_unit #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Hi      (Hi),
        .Lo      (Lo),
        .Zero    (Zero),
        .DivZero (DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {DivZero, Hi, Lo} from plain 64-bit integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r64, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        case (op)
            2'b00:   r64 = sa * sb;
            2'b01:   r64 = ua * ub;
            2'b10:   begin q = sa / sb; r = sa % sb; r64 = {r[31:0], q[31:0]}; end
            default: begin q = ua / ub; r = ua % ub; r64 = {r[31:0], q[31:0]}; end
        endcase
        return {1'b0, r64[63:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Caller is at a negedge; b2b issues in the current (DONE) cycle, poke pulses Start mid-CALC.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, input bit poke);
        logic [64:0] exp;
        int          cnt, busy_n, exp_lat;
        bit          seen;
        exp     = model(op, a, b);
        exp_lat = (op[1] && b == 32'd0) ? 3 : 35;
        if (!b2b) begin
            @(negedge Clk);
            if (prev_valid) begin
                chk("idle_busy", 64'(Busy), 64'd0);
                chk("idle_hold", {Hi, Lo}, {prev_hi, prev_lo});
            end
        end
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk);
        cnt = 1;
        #1 Start = 1'b0; Op = 2'($urandom); A = $urandom; B = $urandom;
        seen = 1'b0; busy_n = 0;
        while (!seen && cnt < 100) begin
            @(negedge Clk);
            if (Done) seen = 1'b1;
            else begin
                if (Busy) busy_n++;
                Start = (poke && cnt == 10);
                @(posedge Clk);
                cnt++;
                #1 Start = 1'b0;
            end
        end
        chk("done_seen",    64'(seen),   64'd1);
        chk("latency",      64'(cnt),    64'(exp_lat));
        chk("busy_cycles",  64'(busy_n), 64'(exp_lat - 1));
        chk("busy_at_done", 64'(Busy),   64'd0);
        chk("hi",           64'(Hi),      64'(exp[63:32]));
        chk("lo",           64'(Lo),      64'(exp[31:0]));
        chk("divzero",      64'(DivZero), 64'(exp[64]));
        chk("zero",         64'(Zero),    64'(exp[63:0] == 64'd0));
        prev_hi = exp[63:32]; prev_lo = exp[31:0]; prev_valid = 1'b1;
    endtask

    initial begin
        bit saw_done;
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        chk("rst_flags", {62'd0, Zero, DivZero}, 64'd0);
        Reset = 1'b1;

        run_op(2'b01, 32'h0000_038E, 32'h0000_0112, 0, 0);
        chk("const_multu", {Hi, Lo}, 64'h0000_0000_0003_CDFC);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("const_mult_m1", {Hi, Lo}, 64'h0000_0000_0000_0001);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("const_multu_max", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b10, 32'h0000_03E8, 32'hFFFF_FFF9, 0, 0);
        chk("const_div_neg", {Hi, Lo}, 64'h0000_0006_FFFF_FF72);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("const_div_ovf", {Hi, Lo}, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'h1234_5678, 32'h0000_0000, 0, 0);
        run_op(2'b01, 32'h0000_0000, 32'h0000_0005, 0, 0);
        run_op(2'b10, 32'hFFFF_FF00, 32'h0000_0000, 0, 0);

        run_op(2'b01, 32'h0000_03E8, 32'h0000_0112, 0, 1);
        run_op(2'b00, $urandom, $urandom, 1, 0);

        @(negedge Clk);
        Start = 1'b1; Op = 2'b01; A = 32'h0001_2345; B = 32'h0000_6789;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_done", 64'(Done), 64'd0);
        chk("midrst_hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) saw_done = 1'b1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);
        prev_hi = '0; prev_lo = '0;
        run_op(2'b10, 32'hFFFF_F830, 32'h0000_0007, 0, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom), pick(), pick(), bit'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
